microcode_sequencer: RTL and testbench

- Parametrised microcoded sequencer; next generation of the fixed-width control unit.
- Microcode store is writable at runtime while halted; opcode, step and flag widths are parameters.
- Adds external stall, halt request, restart, and step-overflow fault detection.
- Drives the datapath control word to the ALU, register file and memory blocks.

---
 rtl/microcode_sequencer.sv | 65 ++++++
 tb/tb_microcode_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: writable-store microcoded control sequencer with stall, halt and step-overflow fault
// Ports: clock/reset (async, active-high); start, halt_req, stall control sequencing;
// flags and the latched opcode form the micro-address with step; bus supplies the opcode;
// prog_we/prog_addr/prog_data write the store while halted; ctrl_out is the registered
// datapath field; running, step, opcode and fault expose sequencer state.
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 8,
    parameter int STEP_WIDTH   = 4,
    parameter int FLAG_WIDTH   = 2,
    parameter int CW_WIDTH     = 24,
    parameter int BUS_WIDTH    = 8
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         halt_req,
    input  logic                                         stall,
    input  logic [FLAG_WIDTH-1:0]                        flags,
    input  logic [BUS_WIDTH-1:0]                         bus,
    input  logic                                         prog_we,
    input  logic [STEP_WIDTH+OPCODE_WIDTH+FLAG_WIDTH-1:0] prog_addr,
    input  logic [CW_WIDTH-1:0]                          prog_data,
    output logic [CW_WIDTH-4:0]                          ctrl_out,
    output logic                                         running,
    output logic [STEP_WIDTH-1:0]                        step,
    output logic [OPCODE_WIDTH-1:0]                      opcode,
    output logic                                         fault
);
    localparam int AW = STEP_WIDTH + OPCODE_WIDTH + FLAG_WIDTH;
    typedef enum logic {HALT, RUN} state_t;
    state_t state;
    logic [CW_WIDTH-1:0] store [2**AW];
    logic [CW_WIDTH-1:0] cw;
    logic overflow;
    assign cw = store[{step, opcode, flags}];
    // stepping past the last micro-step without a next_instr is a microcode bug
    assign overflow = (&step) && !cw[0];
    assign running = state == RUN;
    // store has no reset so microcode survives a reset
    always_ff @(posedge clock) begin
        if (prog_we && state == HALT) store[prog_addr] <= prog_data;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HALT;
            step     <= '0;
            opcode   <= '0;
            ctrl_out <= '0;
            fault    <= 1'b0;
        end else if (state == HALT) begin
            ctrl_out <= '0;
            if (start && !fault) state <= RUN;
        end else if (stall) begin
            // bubble: nothing advances, but a halt request still stops the machine
            ctrl_out <= '0;
            if (halt_req) state <= HALT;
        end else begin
            ctrl_out <= cw[CW_WIDTH-1:3];
            if (cw[1]) opcode <= bus[OPCODE_WIDTH-1:0];
            step <= cw[0] ? '0 : step + 1'b1;
            if (overflow) fault <= 1'b1;
            if (cw[2] || halt_req || overflow) state <= HALT;
        end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: randomized and directed checks of microcode_sequencer against a cycle model
module tb_microcode_sequencer;
    localparam int OW = 8, SW = 4, FW = 2, CW = 24, BW = 8, AW = SW + OW + FW;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0, halt_req = 1'b0, stall = 1'b0, prog_we = 1'b0;
    logic [FW-1:0] flags = '0;
    logic [BW-1:0] bus = '0;
    logic [AW-1:0] prog_addr = '0;
    logic [CW-1:0] prog_data = '0;
    logic [CW-4:0] ctrl_out;
    logic running, fault;
    logic [SW-1:0] step;
    logic [OW-1:0] opcode;
    int checks = 0, errors = 0;

    microcode_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
        .flags(flags), .bus(bus), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ctrl_out(ctrl_out), .running(running), .step(step), .opcode(opcode), .fault(fault)
    );

    always #5 clock = ~clock;

    // behavioural model: plain integers for step/opcode, address formed arithmetically
    logic [CW-1:0] mem [0:(1<<AW)-1];
    logic m_run = 1'b0, m_fault = 1'b0;
    int m_step = 0, m_op = 0;
    logic [CW-4:0] m_ctrl = '0;
    logic [AW-1:0] maddr;
    logic [CW-1:0] mw;
    assign maddr = AW'(m_step * (1 << (OW + FW)) + m_op * (1 << FW) + int'(flags));
    assign mw = mem[maddr];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; m_fault <= 1'b0; m_step <= 0; m_op <= 0; m_ctrl <= '0;
        end else if (!m_run) begin
            if (prog_we) mem[prog_addr] <= prog_data;
            m_ctrl <= '0;
            if (start && !m_fault) m_run <= 1'b1;
        end else if (stall) begin
            m_ctrl <= '0;
            if (halt_req) m_run <= 1'b0;
        end else begin
            m_ctrl <= mw[CW-1:3];
            if (mw[1]) m_op <= int'(bus);
            if (mw[0]) m_step <= 0;
            else if (m_step == (1 << SW) - 1) begin
                m_step <= 0; m_fault <= 1'b1; m_run <= 1'b0;
            end else m_step <= m_step + 1;
            if (mw[2] || halt_req) m_run <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("model", 64'({running, step, opcode, fault, ctrl_out}),
            64'({m_run, SW'(m_step), OW'(m_op), m_fault, m_ctrl}));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [AW-1:0] ad(input int s, input int o, input int f);
        return AW'(s * 1024 + o * 4 + f);
    endfunction

    function automatic logic [CW-1:0] wd(input int c, input bit h, input bit l, input bit n);
        return CW'(c * 8 + int'(h) * 4 + int'(l) * 2 + int'(n));
    endfunction

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state", 64'({running, step, opcode, fault, ctrl_out}), 64'(0));
        for (int a = 0; a < (1 << AW); a++)
            wr(AW'(a), wd($urandom_range(0, (1 << 21) - 1), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1));
        wr(ad(0, 0, 0), wd(1, 0, 1, 0));
        wr(ad(1, 'hA5, 0), wd(2, 0, 0, 1));
        // fetch/load then next_instr
        bus = 8'hA5;
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_running", 64'(running), 64'(1));
        chk("t1_ctrl_idle", 64'(ctrl_out), 64'(0));
        tick();
        chk("t1_ctrl_first", 64'(ctrl_out), 64'(1));
        chk("t1_opcode", 64'(opcode), 64'('hA5));
        chk("t1_step1", 64'(step), 64'(1));
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t1_ctrl_second", 64'(ctrl_out), 64'(2));
        chk("t1_step0", 64'(step), 64'(0));
        chk("t1_halted", 64'(running), 64'(0));
        tick();
        chk("t1_ctrl_after_halt", 64'(ctrl_out), 64'(0));
        // stall bubbles
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stall = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_stall_ctrl", 64'(ctrl_out), 64'(0));
            chk("t2_stall_step", 64'(step), 64'(1));
        end
        stall = 1'b0; halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t2_resume_ctrl", 64'(ctrl_out), 64'(2));
        chk("t2_resume_step", 64'(step), 64'(0));
        // halt_req wins over stall
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        stall = 1'b1; halt_req = 1'b1; tick(); stall = 1'b0; halt_req = 1'b0;
        chk("t2b_halted", 64'({running, step, ctrl_out}), 64'({1'b0, 4'd1, 21'd0}));
        start = 1'b1; tick(); start = 1'b0;
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t2b_word", 64'(ctrl_out), 64'(2));
        // halt bit at step 2, resume at step 3
        wr(ad(1, 'h33, 0), wd(3, 0, 0, 0));
        wr(ad(2, 'h33, 0), wd(4, 1, 0, 0));
        wr(ad(3, 'h33, 0), wd(5, 0, 0, 1));
        wr(ad(0, 'h33, 0), wd(6, 1, 0, 0));
        bus = 8'h33;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("t3_halt_word", 64'({running, step, ctrl_out}), 64'({1'b0, 4'd3, 21'd4}));
        tick();
        chk("t3_ctrl_zero", 64'(ctrl_out), 64'(0));
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t3_resume", 64'({running, step, ctrl_out}), 64'({1'b1, 4'd0, 21'd5}));
        tick();
        chk("t3_second_halt", 64'({running, step, ctrl_out}), 64'({1'b0, 4'd1, 21'd6}));
        // step overflow
        bus = 8'h77;
        for (int s = 1; s < 16; s++) wr(ad(s, 'h77, 0), wd(16 + s, 0, 0, 0));
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        repeat (16) tick();
        chk("t4_overflow", 64'({running, step, fault, ctrl_out}), 64'({1'b0, 4'd0, 1'b1, 21'd31}));
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("t4_start_ignored", 64'({running, fault}), 64'({1'b0, 1'b1}));
        // writes ignored in RUN, honoured in HALT together with start
        wr(ad(1, 'h5A, 0), wd('h11, 0, 0, 1));
        bus = 8'h5A;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        prog_we = 1'b1; prog_addr = ad(1, 'h5A, 0); prog_data = wd('h99, 0, 0, 1);
        tick();
        prog_we = 1'b0;
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t5_run_write_ignored", 64'(ctrl_out), 64'('h11));
        do_reset();
        prog_we = 1'b1; prog_addr = ad(1, 'h5A, 0); prog_data = wd('h22, 0, 0, 1); start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        chk("t5_start_with_write", 64'(running), 64'(1));
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("t5_halt_write", 64'(ctrl_out), 64'('h22));
        // async reset mid-run keeps the store
        bus = 8'h77;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        chk("t6_step5", 64'(step), 64'(5));
        reset = 1'b1;
        #1;
        chk("t6_async_reset", 64'({running, step, opcode, fault, ctrl_out}), 64'(0));
        tick();
        reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("t6_store_kept", 64'({step, opcode, ctrl_out}), 64'({4'd2, 8'h77, 21'd17}));
        // random traffic against the model
        do_reset();
        repeat (3000) begin
            reset = $urandom_range(0, 199) == 0;
            flags = FW'($urandom);
            bus = BW'($urandom);
            stall = $urandom_range(0, 4) == 0;
            halt_req = $urandom_range(0, 19) == 0;
            start = $urandom_range(0, 2) == 0;
            prog_we = $urandom_range(0, 5) == 0;
            prog_addr = AW'($urandom);
            prog_data = CW'($urandom);
            tick();
        end
        reset = 1'b0; start = 1'b0; prog_we = 1'b0; stall = 1'b0; halt_req = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
